inv_key_schedule: RTL

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/inv_key_schedule.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: accepts round key K10 and emits K10 down to K0
// over a valid/ready handshake, one round key per accepted transfer.

module rot_word (
   input  logic [31:0] w,
   output logic [31:0] r
);
   assign r = {w[23:0], w[31:24]};
endmodule

module sub_word (
   input  logic [31:0] w,
   output logic [31:0] s
);
   // Forward AES S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] ofs;
      ofs = {~x, 3'b000};
      return SBOX_TBL[ofs +: 8];
   endfunction

   assign s = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
endmodule

// state | meaning
// IDLE  | waiting for start; outputs quiet
// EMIT  | rk_out holds round key idx, advances one round per accepted transfer
// DONE  | one-cycle done pulse after K0 is taken, then back to IDLE
module inv_key_schedule (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t        state;
   logic [127:0]  key_reg;
   logic [3:0]    idx;

   logic [31:0]   a, b, c, d;
   logic [31:0]   p0, p1, p2, p3;
   logic [31:0]   rot, sub;
   logic [127:0]  prev_key;

   function automatic logic [31:0] rcon(input logic [3:0] i);
      logic [7:0] rc;
      case (i)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h0};
   endfunction

   assign {a, b, c, d} = key_reg;
   assign p3 = d ^ c;
   assign p2 = c ^ b;
   assign p1 = b ^ a;

   rot_word u_rot (.w(p3),  .r(rot));
   sub_word u_sub (.w(rot), .s(sub));

   assign p0       = a ^ sub ^ rcon(idx);
   assign prev_key = {p0, p1, p2, p3};

   // Outputs are registered alongside the state so they never glitch and read
   // as zero whenever rk_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         key_reg  <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_out   <= '0;
         rk_idx   <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= EMIT;
                  key_reg  <= key_in;
                  idx      <= 4'd10;
                  busy     <= 1'b1;
                  rk_valid <= 1'b1;
                  rk_out   <= key_in;
                  rk_idx   <= 4'd10;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  if (idx == 4'd0) begin
                     state    <= DONE;
                     rk_valid <= 1'b0;
                     rk_out   <= '0;
                     rk_idx   <= '0;
                     done     <= 1'b1;
                  end else begin
                     key_reg <= prev_key;
                     idx     <= idx - 4'd1;
                     rk_out  <= prev_key;
                     rk_idx  <= idx - 4'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               rk_valid <= 1'b0;
               rk_out   <= '0;
               rk_idx   <= '0;
            end
         endcase
      end
   end
endmodule
